// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the BittyPro instruction-fetch stage.
// Holds the fetch FSM state encoding and the instruction reset value.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        WAIT_DONE = 2'd2,
        HALT      = 2'd3
    } fetch_state_t;

    localparam int INST_W_DEF = 16;
    localparam int ADDR_W_DEF = 7;

    localparam logic [15:0] INST_RESET = 16'h0000;

endpackage

// File: rtl/inst_fetch_prog_mem.sv
// Single-port program memory: synchronous write, synchronous read (1-cycle latency).
// A same-address write and read in one cycle returns the previous contents.
module prog_mem #(
    parameter int INST_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [INST_W-1:0] wdata,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-supply stage: loadable program memory plus a PC that advances on `done`
// and stops after the instruction at the latched last address completes.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              start,
    input  logic              done,
    output logic [INST_W-1:0] instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] pc_next;
    logic              idle_or_halt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_rdata;

    assign pc_next      = pc + ADDR_W'(1);
    assign idle_or_halt = (state == IDLE) || (state == HALT);

    // The single memory port serves loads while stopped and reads otherwise; a load
    // coinciding with an accepted start loses the port to the read of address 0.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = pc;
        if (idle_or_halt) begin
            if (start) begin
                mem_addr = '0;
            end else begin
                mem_addr = load_addr;
                mem_we   = load_en;
            end
        end else if (state == WAIT_DONE && done) begin
            mem_addr = pc_next;
        end
    end

    prog_mem #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (load_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            last_q      <= '0;
            instruction <= INST_W'(INST_RESET);
            inst_valid  <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc     <= '0;
                        last_q <= last_addr;
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    instruction <= mem_rdata;
                    inst_valid  <= 1'b1;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done) begin
                        inst_valid <= 1'b0;
                        if (pc == last_q) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= pc_next;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a program-level reference model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_inst_fetch;

    localparam int INST_W = 16;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [INST_W-1:0] load_data;
    logic [ADDR_W-1:0] last_addr;
    logic              start;
    logic              done;
    logic [INST_W-1:0] instruction;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    inst_fetch #(.INST_W(INST_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .last_addr   (last_addr),
        .start       (start),
        .done        (done),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .halted      (halted)
    );

    // Program-level model: a running program asks for word pc, which shows up valid
    // one clock after the request clock; done on a valid word either ends or advances.
    logic [INST_W-1:0] m_mem [DEPTH];
    int                m_pc, m_last;
    logic [INST_W-1:0] m_instr;
    bit                m_valid, m_halted, m_running, m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_last = 0; m_instr = '0;
            m_valid = 0; m_halted = 0; m_running = 0; m_pend = 0;
        end else begin
            if (!m_running && load_en && !start)
                m_mem[load_addr] = load_data;
            if (m_pend) begin
                m_instr = m_mem[m_pc];
                m_valid = 1;
                m_pend  = 0;
            end else if (m_valid && done) begin
                m_valid = 0;
                if (m_pc == m_last) begin
                    m_halted  = 1;
                    m_running = 0;
                end else begin
                    m_pc   = (m_pc + 1) % DEPTH;
                    m_pend = 1;
                end
            end else if (!m_running && start) begin
                m_pc = 0; m_last = int'(last_addr); m_halted = 0;
                m_running = 1; m_pend = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_instruction", 32'(instruction), 32'(m_instr));
            chk("model_inst_valid",  32'(inst_valid),  32'(m_valid));
            chk("model_pc",          32'(pc),          32'(m_pc));
            chk("model_halted",      32'(halted),      32'(m_halted));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_word(input int a, input logic [INST_W-1:0] d);
        load_en = 1; load_addr = ADDR_W'(a); load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic pulse_start(input int la);
        start = 1; last_addr = ADDR_W'(la);
        tick();
        start = 0;
    endtask

    task automatic pulse_done();
        done = 1;
        tick();
        done = 0;
    endtask

    task automatic expect_out(input string name, input logic [INST_W-1:0] ins,
                              input bit v, input int p, input bit h);
        chk({name, "_instruction"}, 32'(instruction), 32'(ins));
        chk({name, "_inst_valid"},  32'(inst_valid),  32'(v));
        chk({name, "_pc"},          32'(pc),          32'(p));
        chk({name, "_halted"},      32'(halted),      32'(h));
    endtask

    initial begin
        reset = 1; load_en = 0; load_addr = '0; load_data = '0;
        last_addr = '0; start = 0; done = 0;
        repeat (2) tick();
        expect_out("reset_state", 16'h0000, 0, 0, 0);
        reset = 0;
        cmp_en = 1;
        tick();

        // Three-word program
        load_word(0, 16'h1111);
        load_word(1, 16'h2222);
        load_word(2, 16'h3333);
        pulse_start(2);
        expect_out("in_fetch", 16'h0000, 0, 0, 0);
        tick();
        expect_out("first", 16'h1111, 1, 0, 0);
        pulse_done();
        expect_out("after_done1", 16'h1111, 0, 1, 0);
        tick();
        expect_out("second", 16'h2222, 1, 1, 0);
        pulse_done();
        tick();
        expect_out("third", 16'h3333, 1, 2, 0);
        repeat (20) tick();
        expect_out("hold20", 16'h3333, 1, 2, 0);
        pulse_done();
        expect_out("halt3", 16'h3333, 0, 2, 1);
        repeat (3) tick();

        // Restart from HALT; done during FETCH is ignored; load during WAIT_DONE dropped
        pulse_start(2);
        pulse_done();
        expect_out("done_in_fetch", 16'h1111, 1, 0, 0);
        load_word(1, 16'hDEAD);
        pulse_done();
        tick();
        expect_out("dropped_write", 16'h2222, 1, 1, 0);

        // Asynchronous reset between clock edges
        #2 reset = 1;
        #1 expect_out("async_reset", 16'h0000, 0, 0, 0);
        tick();
        reset = 0;
        tick();
        pulse_start(2);
        tick();
        expect_out("after_reset", 16'h1111, 1, 0, 0);
        start = 1;
        pulse_done();
        start = 0;
        tick();
        expect_out("done_beats_start", 16'h2222, 1, 1, 0);
        pulse_done();
        tick();
        pulse_done();
        expect_out("halt_again", 16'h3333, 0, 2, 1);

        // Single-instruction program, then reload and rerun
        load_word(0, 16'hABCD);
        pulse_start(0);
        tick();
        expect_out("single", 16'hABCD, 1, 0, 0);
        pulse_done();
        expect_out("single_halt", 16'hABCD, 0, 0, 1);
        load_word(0, 16'h5555);
        pulse_start(0);
        tick();
        expect_out("reload", 16'h5555, 1, 0, 0);
        pulse_done();

        // Full-depth program: pc runs 0..127 without wrapping
        for (int i = 0; i < DEPTH; i++)
            load_word(i, INST_W'((i * 257) ^ 16'h5A5A));
        pulse_start(DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("full_pc", 32'(pc), 32'(i));
            chk("full_instruction", 32'(instruction), 32'(INST_W'((i * 257) ^ 16'h5A5A)));
            pulse_done();
        end
        expect_out("full_halt", INST_W'((127 * 257) ^ 16'h5A5A), 0, 127, 1);
        repeat (2) tick();

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
